// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths and the MEM/WB pipeline slot layout
package wb_stage_pkg;
    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam logic [REG_W-1:0] ZERO_WORD = '0;
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic [REG_W-1:0]      wdata;
        logic                  whilo;
        logic [REG_W-1:0]      hi;
        logic [REG_W-1:0]      lo;
        logic                  llbit_we;
        logic                  llbit_value;
    } wb_slot_t;
    localparam wb_slot_t BUBBLE = '0;
endpackage

// File: rtl/wb_stage_hilo_reg.sv
// hilo_reg: architectural HI/LO storage with a single write enable
module hilo_reg
    import wb_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [REG_W-1:0] wr_hi,
    input  logic [REG_W-1:0] wr_lo,
    output logic [REG_W-1:0] hi,
    output logic [REG_W-1:0] lo
);
    // HI/LO are written together by mult/div/mthi/mtlo results
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= ZERO_WORD;
            lo <= ZERO_WORD;
        end else if (we) begin
            hi <= wr_hi;
            lo <= wr_lo;
        end
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register, regfile write port, HI/LO and LLbit state, retire counter
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_mem,
    input  logic                  stall_wb,
    input  logic                  flush,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [REG_W-1:0]      mem_wdata,
    input  logic                  mem_whilo,
    input  logic [REG_W-1:0]      mem_hi,
    input  logic [REG_W-1:0]      mem_lo,
    input  logic                  mem_llbit_we,
    input  logic                  mem_llbit_value,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_waddr,
    output logic [REG_W-1:0]      wb_wdata,
    output logic [REG_W-1:0]      hi_o,
    output logic [REG_W-1:0]      lo_o,
    output logic                  llbit_o,
    output logic [CNT_W-1:0]      retired_o
);
    wb_slot_t         slot;
    wb_slot_t         incoming;
    logic             bubble;
    logic             hold;
    logic             llbit_reg;
    logic [REG_W-1:0] hi_reg;
    logic [REG_W-1:0] lo_reg;
    // Gather the MEM-stage results into one slot; decide bubble vs hold
    always_comb begin
        incoming = '{valid: mem_valid, wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata,
                     whilo: mem_whilo, hi: mem_hi, lo: mem_lo,
                     llbit_we: mem_llbit_we, llbit_value: mem_llbit_value};
        bubble   = flush || (stall_mem && !stall_wb);
        hold     = !bubble && stall_mem;
    end
    // MEM/WB register: flush or a MEM-only stall inserts a bubble, a full stall holds
    always_ff @(posedge clk) begin
        if (rst || bubble)
            slot <= BUBBLE;
        else if (!stall_mem)
            slot <= incoming;
    end
    hilo_reg u_hilo (
        .clk   (clk),
        .rst   (rst),
        .we    (slot.whilo),
        .wr_hi (slot.hi),
        .wr_lo (slot.lo),
        .hi    (hi_reg),
        .lo    (lo_reg)
    );
    // LLbit: an exception flush clears the link even if an LL/SC is committing
    always_ff @(posedge clk) begin
        if (rst || flush)
            llbit_reg <= 1'b0;
        else if (slot.llbit_we)
            llbit_reg <= slot.llbit_value;
    end
    // Count an instruction on the edge it leaves WB, so a held one is counted once
    always_ff @(posedge clk) begin
        if (rst)
            retired_o <= '0;
        else if (slot.valid && !hold)
            retired_o <= retired_o + CNT_W'(1);
    end
    // Regfile port straight from the slot; HI/LO/LLbit reads bypass the pending write
    always_comb begin
        wb_we    = slot.wreg;
        wb_waddr = slot.wd;
        wb_wdata = slot.wdata;
        hi_o     = slot.whilo ? slot.hi : hi_reg;
        lo_o     = slot.whilo ? slot.lo : lo_reg;
        llbit_o  = slot.llbit_we ? slot.llbit_value : llbit_reg;
    end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors with a queued scoreboard for wb_stage
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst, stall_mem, stall_wb, flush, mem_valid, mem_wreg, mem_whilo;
    logic        mem_llbit_we, mem_llbit_value;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic        wb_we, llbit_o;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata, hi_o, lo_o;
    logic [3:0]  retired_o;
    int          checks = 0;
    int          fails = 0;
    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ll;
        logic [3:0]  ret;
    } exp_t;
    exp_t sb[$];
    wb_stage #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
        .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_llbit_we(mem_llbit_we), .mem_llbit_value(mem_llbit_value),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .hi_o(hi_o), .lo_o(lo_o), .llbit_o(llbit_o), .retired_o(retired_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", n, a, e, $time);
        end
    endtask
    // One cycle of stimulus plus the outputs expected right after the coming edge
    task automatic go(input logic r, sm, sw, fl, v, input logic [4:0] wd, input logic wr,
                      input logic [31:0] wdat, input logic wh, input logic [31:0] h, l,
                      input logic lwe, lv, input logic ewe, input logic [4:0] ewa,
                      input logic [31:0] ewd, eh, el, input logic ell, input logic [3:0] eret);
        @(negedge clk);
        rst = r; stall_mem = sm; stall_wb = sw; flush = fl; mem_valid = v;
        mem_wd = wd; mem_wreg = wr; mem_wdata = wdat; mem_whilo = wh;
        mem_hi = h; mem_lo = l; mem_llbit_we = lwe; mem_llbit_value = lv;
        sb.push_back('{ewe, ewa, ewd, eh, el, ell, eret});
    endtask
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_we", 32'(wb_we), 32'(e.we));
                chk("wb_waddr", 32'(wb_waddr), 32'(e.waddr));
                chk("wb_wdata", wb_wdata, e.wdata);
                chk("hi_o", hi_o, e.hi);
                chk("lo_o", lo_o, e.lo);
                chk("llbit_o", 32'(llbit_o), 32'(e.ll));
                chk("retired_o", 32'(retired_o), 32'(e.ret));
            end
        end
    end
    initial begin
        // reset with junk on the MEM side
        go(1,0,0,0,1,5'd7,1,32'hFFFF_FFFF,1,32'h9,32'h9,1,1,  0,0,0,0,0,0,0);
        go(1,0,0,0,1,5'd8,1,32'h1234_5678,1,32'h8,32'h8,1,1,  0,0,0,0,0,0,0);
        // basic writeback, then a GPR0 write passes through
        go(0,0,0,0,1,5'd5,1,32'hDEAD_BEEF,0,0,0,0,0,  1,5'd5,32'hDEAD_BEEF,0,0,0,0);
        go(0,0,0,0,1,5'd0,1,32'h0000_0F00,0,0,0,0,0,  1,5'd0,32'h0000_0F00,0,0,0,1);
        go(0,0,0,0,1,5'd9,1,32'h0000_A5A5,0,0,0,0,0,  1,5'd9,32'h0000_A5A5,0,0,0,2);
        // MEM-only stall inserts bubbles
        go(0,1,0,0,1,5'd7,1,32'h0000_1234,0,0,0,0,0,  0,0,0,0,0,0,3);
        go(0,1,0,0,1,5'd7,1,32'h0000_1234,0,0,0,0,0,  0,0,0,0,0,0,3);
        // full stall holds for 3 cycles without counting or capturing
        go(0,0,0,0,1,5'd3,1,32'h0000_3333,0,0,0,0,0,  1,5'd3,32'h0000_3333,0,0,0,3);
        for (int i = 0; i < 3; i++)
            go(0,1,1,0,1,5'd12,1,32'hCCCC_CCCC,1,32'hFFFF,32'hEEEE,1,1,  1,5'd3,32'h0000_3333,0,0,0,3);
        go(0,0,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0,0,4);
        // HI/LO: bypass then register
        go(0,0,0,0,1,0,0,0,1,32'h11,32'h22,0,0,  0,0,0,32'h11,32'h22,0,4);
        go(0,0,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,32'h11,32'h22,0,5);
        go(0,0,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,32'h11,32'h22,0,5);
        go(0,0,0,0,1,0,0,0,1,32'hAAAA_0000,32'h5555,0,0,  0,0,0,32'hAAAA_0000,32'h5555,0,5);
        go(0,0,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,32'hAAAA_0000,32'h5555,0,6);
        // LLbit set, then flush beats a second LLbit write
        go(0,0,0,0,1,0,0,0,0,0,0,1,1,  0,0,0,32'hAAAA_0000,32'h5555,1,6);
        go(0,0,0,0,1,5'd4,1,32'h44,0,0,0,1,1,  1,5'd4,32'h44,32'hAAAA_0000,32'h5555,1,7);
        go(0,0,0,1,1,5'd6,1,32'h66,0,0,0,1,1,  0,0,0,32'hAAAA_0000,32'h5555,0,8);
        go(0,0,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,32'hAAAA_0000,32'h5555,0,8);
        // LLbit set then cleared by a write of 0
        go(0,0,0,0,1,0,0,0,0,0,0,1,1,  0,0,0,32'hAAAA_0000,32'h5555,1,8);
        go(0,0,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,32'hAAAA_0000,32'h5555,1,9);
        go(0,0,0,0,1,0,0,0,0,0,0,1,0,  0,0,0,32'hAAAA_0000,32'h5555,0,9);
        go(0,0,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,32'hAAAA_0000,32'h5555,0,10);
        // counter wrap: from reset, 17 retirements on a 4-bit counter leave 1
        go(1,0,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0,0,0);
        for (int i = 1; i <= 17; i++)
            go(0,0,0,0,1,5'(i),1,32'(i),0,0,0,0,0,  1,5'(i),32'(i),0,0,0,4'((i - 1) % 16));
        go(0,0,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,0,0,0,4'd1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
